snn_batch_scheduler: RTL and testbench

Sequences back-to-back inference runs of the SNN core over a batch of stored spike patterns, with no AXI intervention between samples. For each sample it selects the spike-pattern batch, resets the network, enables it for a programmed number of timesteps, and copies every output neuron's spike count into a results RAM. It sits between the AXI config registers and the `if_network` / `spike_pattern_mem` / `spike_counter` datapath. It replaces per-sample software polling of `ctrl[0]` and the output-count RAM.

---
 rtl/snn_sched_pkg.sv | 17 +
 rtl/snn_batch_scheduler_if.sv | 42 ++++
 rtl/counter.sv | 22 ++
 rtl/snn_batch_scheduler.sv | 163 ++++++++++++++++
 tb/tb_snn_batch_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types for the SNN batch scheduler.
// State encoding for the per-sample sequencing FSM.
package snn_sched_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DUMP,
      S_NEXT,
      S_FINISH
   } sched_state_t;

endpackage

// File: rtl/snn_batch_scheduler_if.sv
// Config-side and datapath-side signals of the batch scheduler.
// The master drives the run request; the slave sequences the datapath.
interface snn_batch_scheduler_if #(
   parameter int NUM_OUTPUTS       = 1,
   parameter int BATCH_ADDR_WIDTH  = 6,
   parameter int RESULT_ADDR_WIDTH = 10,
   parameter int COUNT_WIDTH       = 32
) ();

   logic                              start;
   logic                              abort;
   logic [BATCH_ADDR_WIDTH:0]         num_samples;
   logic [BATCH_ADDR_WIDTH-1:0]       first_batch;
   logic [COUNT_WIDTH-1:0]            sim_time;
   logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] spike_counts;

   logic [BATCH_ADDR_WIDTH-1:0]       batch_sel;
   logic                              network_rst;
   logic                              network_en;
   logic [COUNT_WIDTH-1:0]            timestep;
   logic                              res_wen;
   logic [RESULT_ADDR_WIDTH-1:0]      res_addr;
   logic [COUNT_WIDTH-1:0]            res_data;
   logic [BATCH_ADDR_WIDTH:0]         sample_idx;
   logic                              busy;
   logic                              done;

   modport master (
      output start, abort, num_samples, first_batch,
      output sim_time, spike_counts,
      input  batch_sel, network_rst, network_en, timestep,
      input  res_wen, res_addr, res_data, sample_idx, busy, done
   );

   modport slave (
      input  start, abort, num_samples, first_batch,
      input  sim_time, spike_counts,
      output batch_sel, network_rst, network_en, timestep,
      output res_wen, res_addr, res_data, sample_idx, busy, done
   );

endinterface

// File: rtl/counter.sv
// Up-counter with synchronous clear and count enable.
module counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_count <= '0;
      else if (i_en)
         r_count <= r_count + WIDTH'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/snn_batch_scheduler.sv
// Runs the SNN core over a batch of stored spike patterns and
// dumps every output neuron's spike count into the results RAM.
module snn_batch_scheduler
   import snn_sched_pkg::*;
#(
   parameter int NUM_OUTPUTS       = 1,
   parameter int OUT_IDX_BITS      = 4,
   parameter int BATCH_ADDR_WIDTH  = 6,
   parameter int RESULT_ADDR_WIDTH = 10,
   parameter int COUNT_WIDTH       = 32
) (
   input logic                 clk,
   input logic                 rst,
   snn_batch_scheduler_if.slave bus
);

   localparam int IDX_W = BATCH_ADDR_WIDTH + 1;

   sched_state_t                 r_state;
   logic [IDX_W-1:0]             r_num;
   logic [IDX_W-1:0]             r_sample_idx;
   logic [BATCH_ADDR_WIDTH-1:0]  r_first;
   logic [BATCH_ADDR_WIDTH-1:0]  r_batch_sel;
   logic [COUNT_WIDTH-1:0]       r_sim_time;
   logic [COUNT_WIDTH-1:0]       r_res_data;
   logic [RESULT_ADDR_WIDTH-1:0] r_res_addr;
   logic [OUT_IDX_BITS-1:0]      r_k;
   logic                         r_network_rst;
   logic                         r_network_en;
   logic                         r_res_wen;
   logic                         r_busy;
   logic                         r_done;

   logic                         w_cnt_rst;
   logic [COUNT_WIDTH-1:0]       w_timestep;
   logic [IDX_W-1:0]             w_idx_inc;
   logic [OUT_IDX_BITS-1:0]      w_k_nxt;
   logic                         w_k_last;
   logic                         w_run_last;
   logic [RESULT_ADDR_WIDTH-1:0] w_addr_nxt;
   logic [COUNT_WIDTH-1:0]       w_count_sel;

   assign w_cnt_rst = rst || (r_state == S_CLEAR);

   counter #(.WIDTH(COUNT_WIDTH)) u_timestep (
      .i_clk   (clk),
      .i_rst   (w_cnt_rst),
      .i_en    (r_network_en),
      .o_count (w_timestep)
   );

   assign w_idx_inc  = r_sample_idx + IDX_W'(1);
   assign w_k_nxt    = (r_state == S_DUMP) ?
                       r_k + OUT_IDX_BITS'(1) : '0;
   assign w_k_last   = (r_k == OUT_IDX_BITS'(NUM_OUTPUTS - 1));
   assign w_run_last = (w_timestep == r_sim_time - COUNT_WIDTH'(1));
   // Address wraps silently at the RAM depth.
   assign w_addr_nxt = RESULT_ADDR_WIDTH'(
      32'(r_sample_idx) * NUM_OUTPUTS + 32'(w_k_nxt));

   always_comb begin
      w_count_sel = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++)
         if (w_k_nxt == OUT_IDX_BITS'(i))
            w_count_sel = bus.spike_counts[i*COUNT_WIDTH +: COUNT_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_num         <= '0;
         r_sample_idx  <= '0;
         r_first       <= '0;
         r_batch_sel   <= '0;
         r_sim_time    <= '0;
         r_res_data    <= '0;
         r_res_addr    <= '0;
         r_k           <= '0;
         r_network_rst <= 1'b0;
         r_network_en  <= 1'b0;
         r_res_wen     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_network_rst <= 1'b0;
         r_network_en  <= 1'b0;
         r_res_wen     <= 1'b0;
         r_done        <= 1'b0;
         if (r_state != S_IDLE && bus.abort) begin
            r_state       <= S_IDLE;
            r_network_rst <= 1'b1;
            r_busy        <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: if (bus.start) begin
                  r_num        <= bus.num_samples;
                  r_first      <= bus.first_batch;
                  r_sim_time   <= bus.sim_time;
                  r_sample_idx <= '0;
                  r_batch_sel  <= bus.first_batch;
                  r_busy       <= 1'b1;
                  if (bus.num_samples == '0) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= S_CLEAR;
                     r_network_rst <= 1'b1;
                  end
               end
               S_CLEAR: if (r_sim_time == '0) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_state      <= S_RUN;
                  r_network_en <= 1'b1;
               end
               S_RUN: if (w_run_last)
                  r_state <= S_DRAIN;
               else
                  r_network_en <= 1'b1;
               S_DRAIN, S_DUMP:
                  if (r_state == S_DUMP && w_k_last) begin
                     r_state <= S_NEXT;
                  end else begin
                     r_state    <= S_DUMP;
                     r_k        <= w_k_nxt;
                     r_res_wen  <= 1'b1;
                     r_res_addr <= w_addr_nxt;
                     r_res_data <= w_count_sel;
                  end
               S_NEXT: begin
                  r_sample_idx <= w_idx_inc;
                  r_batch_sel  <= r_first +
                                  w_idx_inc[BATCH_ADDR_WIDTH-1:0];
                  if (w_idx_inc == r_num) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= S_CLEAR;
                     r_network_rst <= 1'b1;
                  end
               end
               S_FINISH: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.batch_sel   = r_batch_sel;
   assign bus.network_rst = r_network_rst;
   assign bus.network_en  = r_network_en;
   assign bus.timestep    = w_timestep;
   assign bus.res_wen     = r_res_wen;
   assign bus.res_addr    = r_res_addr;
   assign bus.res_data    = r_res_data;
   assign bus.sample_idx  = r_sample_idx;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

endmodule

// File: tb/tb_snn_batch_scheduler.sv
// Bench for snn_batch_scheduler: two instances (1024- and 4-word
// result RAMs) share stimulus; writes are checked off a scoreboard.
module tb_snn_batch_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   snn_batch_scheduler_if #(.NUM_OUTPUTS(2)) b0 ();
   snn_batch_scheduler_if #(
      .NUM_OUTPUTS(2), .RESULT_ADDR_WIDTH(2)) b1 ();

   snn_batch_scheduler #(.NUM_OUTPUTS(2)) u0 (
      .clk (clk), .rst (rst), .bus (b0.slave));

   snn_batch_scheduler #(
      .NUM_OUTPUTS(2), .RESULT_ADDR_WIDTH(2)) u1 (
      .clk (clk), .rst (rst), .bus (b1.slave));

   assign b1.start       = b0.start;
   assign b1.abort       = b0.abort;
   assign b1.num_samples = b0.num_samples;
   assign b1.first_batch = b0.first_batch;
   assign b1.sim_time    = b0.sim_time;

   // Counter stub: neuron i of sample s reports s*10+i.
   always_comb begin
      b0.spike_counts = {32'(32'(b0.sample_idx) * 10 + 1),
                         32'(32'(b0.sample_idx) * 10)};
      b1.spike_counts = {32'(32'(b1.sample_idx) * 10 + 1),
                         32'(32'(b1.sample_idx) * 10)};
   end

   typedef struct {
      int addr;
      int data;
   } wr_t;

   typedef struct {
      int n;
      int first;
      int s;
      int poke;
      int lat;
   } vec_t;

   wr_t  q0[$];
   wr_t  q1[$];
   wr_t  e0;
   wr_t  e1;
   int   bsel_obs[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   en_cnt;
   int   rst_cnt;
   int   done_cnt;
   int   done1_cnt;
   vec_t vecs[6];

   task automatic chk(input string name,
                      input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) if (!rst) begin
      if (b0.res_wen) begin
         if (q0.size() == 0) begin
            chk("wr0_unexpected", 1, 0);
         end else begin
            e0 = q0.pop_front();
            chk("wr0_addr", b0.res_addr, e0.addr);
            chk("wr0_data", b0.res_data, e0.data);
         end
      end
      if (b0.network_en) en_cnt++;
      if (b0.network_rst && b0.busy) begin
         rst_cnt++;
         bsel_obs.push_back(int'(b0.batch_sel));
      end
      if (b0.done) done_cnt++;
   end

   always @(negedge clk) if (!rst) begin
      if (b1.res_wen) begin
         if (q1.size() == 0) begin
            chk("wr1_unexpected", 1, 0);
         end else begin
            e1 = q1.pop_front();
            chk("wr1_addr", b1.res_addr, e1.addr);
            chk("wr1_data", b1.res_data, e1.data);
         end
      end
      if (b1.done) done1_cnt++;
   end

   task automatic push_exp(input int n);
      for (int s = 0; s < n; s++)
         for (int i = 0; i < 2; i++) begin
            q0.push_back('{(s * 2 + i) % 1024, s * 10 + i});
            q1.push_back('{(s * 2 + i) % 4, s * 10 + i});
         end
   endtask

   task automatic clr_stats();
      en_cnt    = 0;
      rst_cnt   = 0;
      done_cnt  = 0;
      done1_cnt = 0;
      bsel_obs.delete();
   endtask

   task automatic run_case(input vec_t v);
      int lat;
      clr_stats();
      push_exp(v.n);
      b0.num_samples = 7'(v.n);
      b0.first_batch = 6'(v.first);
      b0.sim_time    = 32'(v.s);
      b0.start       = 1'b1;
      lat = -1;
      for (int c = 1; c <= 300 && lat < 0; c++) begin
         @(posedge clk);
         @(negedge clk);
         b0.start = 1'b0;
         if (c == 1) chk("busy_after_start", b0.busy, 1);
         if (v.poke != 0 && c == 2) begin
            b0.start       = 1'b1;
            b0.num_samples = 7'(5);
            b0.first_batch = 6'(1);
            b0.sim_time    = 32'(9);
         end
         if (b0.done) lat = c;
      end
      b0.start = 1'b0;
      chk("done_latency", lat, v.lat);
      repeat (3) @(negedge clk);
      chk("busy_idle", b0.busy, 0);
      chk("en_cycles", en_cnt, v.n * v.s);
      chk("clear_pulses", rst_cnt, v.n);
      chk("done_pulses", done_cnt, 1);
      chk("done1_pulses", done1_cnt, 1);
      chk("wr0_left", q0.size(), 0);
      chk("wr1_left", q1.size(), 0);
      chk("bsel_count", bsel_obs.size(), v.n);
      for (int s = 0; s < v.n && s < bsel_obs.size(); s++)
         chk("batch_sel", bsel_obs[s], (v.first + s) % 64);
      q0.delete();
      q1.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, b0.busy, 0);
      chk({tag, "_done"}, b0.done, 0);
      chk({tag, "_nrst"}, b0.network_rst, 0);
      chk({tag, "_nen"}, b0.network_en, 0);
      chk({tag, "_wen"}, b0.res_wen, 0);
      chk({tag, "_addr"}, b0.res_addr, 0);
      chk({tag, "_data"}, b0.res_data, 0);
      chk({tag, "_bsel"}, b0.batch_sel, 0);
      chk({tag, "_idx"}, b0.sample_idx, 0);
      chk({tag, "_tstep"}, b0.timestep, 0);
      chk({tag, "_wen1"}, b1.res_wen, 0);
   endtask

   initial begin
      bit found;
      vecs[0] = '{3, 5, 4, 0, 28};
      vecs[1] = '{1, 0, 0, 0, 6};
      vecs[2] = '{0, 9, 5, 0, 1};
      vecs[3] = '{2, 63, 1, 0, 13};
      vecs[4] = '{2, 3, 2, 1, 15};
      vecs[5] = '{1, 10, 7, 0, 13};
      b0.start       = 1'b0;
      b0.abort       = 1'b0;
      b0.num_samples = '0;
      b0.first_batch = '0;
      b0.sim_time    = '0;
      clr_stats();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_case(vecs[i]);

      // Abort in sample 1's RUN phase.
      clr_stats();
      push_exp(1);
      b0.num_samples = 7'(3);
      b0.first_batch = 6'(5);
      b0.sim_time    = 32'(4);
      b0.start       = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         b0.start = 1'b0;
         if (b0.sample_idx == 7'(1) && b0.network_en) found = 1'b1;
      end
      chk("abort_reached_run", found, 1);
      b0.abort = 1'b1;
      @(negedge clk);
      b0.abort = 1'b0;
      chk("abort_busy", b0.busy, 0);
      chk("abort_nrst", b0.network_rst, 1);
      chk("abort_nen", b0.network_en, 0);
      repeat (40) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_wr0_left", q0.size(), 0);
      chk("abort_wr1_left", q1.size(), 0);
      q0.delete();
      q1.delete();
      run_case(vecs[0]);

      // Reset in the middle of DUMP.
      clr_stats();
      push_exp(1);
      b0.num_samples = 7'(1);
      b0.first_batch = 6'(7);
      b0.sim_time    = 32'(3);
      b0.start       = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         b0.start = 1'b0;
         if (b0.res_wen) found = 1'b1;
      end
      chk("dump_reached", found, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      rst = 1'b0;
      q0.delete();
      q1.delete();
      @(negedge clk);
      run_case(vecs[1]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
